// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit timing.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 100 MHz board clock at 9600 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned FRAME_BITS           = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-in first-out buffer with registered occupancy count.
// Head entry is readable combinationally; pushes to full and pops from empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned COUNT_W = AW + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == COUNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are serialised
// LSB first, with back-to-back frames sent without an idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 last_bit;

    // Writes are refused while reset is held so nothing slips in during a flush
    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready && reset;
    assign bit_end   = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_idx_q == BIT_W'(DATA_BITS - 1));
    assign TxD       = txd_q;
    assign busy      = busy_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and serialiser; TxD is computed one edge early so the line comes straight from a flop
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    txd_d      = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    txd_d      = shift_q[0];
                    shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (last_bit) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_idx_d = '0;
                        txd_d     = 1'b0;
                        state_d   = ST_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes TxD frames and compares
// each against bytes queued when the producer handshake completed.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       TxD;
    logic       busy;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    int         frame_starts[$];
    int         edge_cnt = 0;
    int         stall_cycles = 0;
    int         max_count = 0;
    bit         ready_err = 1'b0;
    bit         idle_busy_err = 1'b0;

    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;
    bit         shape_err = 1'b0;
    bit         busy_err = 1'b0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TxD        (TxD),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: samples every cycle on the falling edge and rebuilds each frame
    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else begin
            if (tx_ready !== (fifo_count < 3'(DEPTH))) ready_err = 1'b1;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (!mon_active) begin
                if (TxD === 1'b1 && busy !== 1'b0) idle_busy_err = 1'b1;
                if (TxD === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_byte   = '0;
                    shape_err  = 1'b0;
                    busy_err   = 1'b0;
                    frame_starts.push_back(edge_cnt);
                end
            end
            if (mon_active) begin
                int idx;
                int ph;
                idx = mon_cnt / CPB;
                ph  = mon_cnt % CPB;
                if (busy !== 1'b1) busy_err = 1'b1;
                if (idx == 0) begin
                    if (TxD !== 1'b0) shape_err = 1'b1;
                end else if (idx <= 8) begin
                    if (ph == 0) mon_byte[idx-1] = TxD;
                    else if (TxD !== mon_byte[idx-1]) shape_err = 1'b1;
                end else if (TxD !== 1'b1) begin
                    shape_err = 1'b1;
                end
                if (mon_cnt == int'(FRAME) - 1) begin
                    mon_active = 1'b0;
                    check_eq("frame_shape", 32'(shape_err), 0);
                    check_eq("frame_busy", 32'(busy_err), 0);
                    check_eq("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check_eq("frame_data", 32'(mon_byte), 32'(exp_q.pop_front()));
                end else begin
                    mon_cnt++;
                end
            end
        end
    end

    // Offer a byte until accepted; tx_data is scrambled on stalled cycles
    task automatic send_byte(input logic [7:0] b, output int acc_edge);
        bit done;
        done = 1'b0;
        acc_edge = -1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            if (tx_ready) begin
                tx_data = b;
                exp_q.push_back(b);
                @(posedge clk);
                #1;
                acc_edge = edge_cnt;
                tx_valid = 1'b0;
                done = 1'b1;
            end else begin
                tx_data = 8'($urandom);
                stall_cycles++;
            end
        end
        tx_valid = 1'b0;
        check_eq("send_accepted", 32'(done), 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy && fifo_count == 0 && !mon_active && TxD === 1'b1) done = 1'b1;
        end
        check_eq("idle_reached", 32'(done), 1);
        check_eq("sb_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int e;
        int e2;
        int n0;
        int s0;
        int st0;
        bit hit;

        #1 $display("[TB] uart_tx bench start");
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_txd", 32'(TxD), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_count", 32'(fifo_count), 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(tx_ready), 1);

        // Single byte: start bit on the edge after acceptance
        n0 = frame_starts.size();
        send_byte(8'h55, e);
        wait_idle();
        check_eq("one_frame", 32'(frame_starts.size() - n0), 1);
        if (frame_starts.size() > n0) check_eq("start_latency", 32'(frame_starts[n0]), 32'(e + 1));

        // Back-to-back frames with no idle gap
        n0 = frame_starts.size();
        send_byte(8'h00, e);
        send_byte(8'hFF, e2);
        wait_idle();
        check_eq("two_frames", 32'(frame_starts.size() - n0), 2);
        if (frame_starts.size() >= n0 + 2)
            check_eq("no_gap", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'(FRAME));

        // Six continuous writes overrun the buffer and must stall, not drop
        n0 = frame_starts.size();
        st0 = stall_cycles;
        max_count = 0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + 8'(i * 17)), e);
        wait_idle();
        check_eq("six_frames", 32'(frame_starts.size() - n0), 6);
        check_eq("fifo_filled", 32'(max_count), 32'(DEPTH));
        check_eq("stall_seen", 32'(stall_cycles > st0), 1);

        // Reset during data bit 3 of 0xA5 with two bytes still buffered
        n0 = frame_starts.size();
        send_byte(8'hA5, e);
        send_byte(8'h11, e2);
        send_byte(8'h22, e2);
        s0 = e + 1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (edge_cnt >= s0 + int'(4 * CPB) + 1) hit = 1'b1;
        end
        check_eq("reached_bit3", 32'(hit), 1);
        check_eq("pre_rst_count", 32'(fifo_count), 2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_txd", 32'(TxD), 1);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_count", 32'(fifo_count), 0);
        reset = 1'b1;
        n0 = frame_starts.size();
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check_eq("abort_silent", 32'(frame_starts.size() - n0), 0);
        check_eq("abort_idle_txd", 32'(TxD), 1);

        // Stream bytes 2..11 through the line decoder
        n0 = frame_starts.size();
        for (int b = 2; b <= 11; b++) send_byte(8'(b), e);
        wait_idle();
        check_eq("stream_frames", 32'(frame_starts.size() - n0), 10);

        check_eq("ready_tracks_count", 32'(ready_err), 0);
        check_eq("busy_low_when_idle", 32'(idle_busy_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
